ex_wb_pipe_stage: RTL and testbench
===================================

Name: ex_wb_pipe_stage

Overview:
- Parametrised EX->WB pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Supports a synchronous flush and exposes forwarding-hit flags to the ID/EX hazard logic.
- Sits between the ALU output and the register-file write port.
- Lets WB back-pressure EX without losing the ALU result produced in the stall cycle.

Parameters:
- DATA_W, 8: ALU result width.
- REG_ADDR_W, 3: destination register address width.
- ZERO_REG_RO, 1: when 1, register 0 is read-only. Writes to it are never flagged as forwarding hits.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- flush  input  1  synchronous kill of all buffered entries.
- in_valid  input  1  EX presents a result.
- in_ready  output  1  stage can accept this cycle.
- RegWrite_in  input  1  write-enable from ID/EX.
- ALU_result_in  input  DATA_W  ALU result.
- Write_reg_in  input  REG_ADDR_W  destination register.
- out_valid  output  1  WB entry valid.
- out_ready  input  1  WB consumes the entry this cycle.
- RegWrite_out  output  1  equals out_valid AND head RegWrite.
- ALU_result_out  output  DATA_W  head result.
- Write_reg_out  output  REG_ADDR_W  head destination.
- rs_a  input  REG_ADDR_W  source operand A being decoded.
- rs_b  input  REG_ADDR_W  source operand B being decoded.
- fwd_a_hit  output  1  head matches rs_a (combinational).
- fwd_b_hit  output  1  head matches rs_b (combinational).
- occupancy  output  2  entries held: 0, 1 or 2.

Behaviour:
- Storage: head register H and skid register S. Each holds {RegWrite, ALU_result, Write_reg}.
- State machine: EMPTY (occupancy 0), ONE (H valid), TWO (H and S valid).
- Definitions: acc = in_valid AND in_ready; pop = out_valid AND out_ready.
- in_ready = (state != TWO). It is registered-state-derived only, with no combinational path from out_ready.
- out_valid = (state != EMPTY). Outputs are driven from H.
- EMPTY:
  - acc -> ONE, H <= in.
  - No acc -> hold.
- ONE:
  - acc AND pop -> ONE, H <= in (full throughput, 1 entry/cycle).
  - acc AND NOT pop -> TWO, S <= in, H holds.
  - NOT acc AND pop -> EMPTY.
  - Otherwise -> hold.
- TWO:
  - pop -> ONE, H <= S.
  - No pop -> hold. No accept is possible because in_ready = 0.
- Latency: an entry accepted at edge N is on the outputs after edge N when the stage was EMPTY, or ONE with pop.
- Ordering: strict FIFO; no entry is dropped or duplicated.
- flush (sync, checked before the handshake):
  - Next state is EMPTY.
  - H.RegWrite and S.RegWrite are cleared.
  - A simultaneous acc is discarded, and pop has no effect beyond the flush.
- reset (async, highest priority):
  - state EMPTY, H and S fully zero.
  - All outputs 0: out_valid, RegWrite_out, ALU_result_out, Write_reg_out, occupancy, fwd_*_hit.
  - in_ready = 1 once reset is deasserted.
  - Reset mid-transfer loses both entries with no partial state.
- Forwarding: fwd_x_hit = out_valid AND H.RegWrite AND (H.Write_reg == rs_x) AND NOT (ZERO_REG_RO AND rs_x == 0).
- Data widths: data is passed through unmodified with no truncation. Write_reg_out is exactly REG_ADDR_W bits.
- Invalid head: when out_valid = 0, ALU_result_out and Write_reg_out keep their last values (don't-care to WB). RegWrite_out must be 0.

Test Plan:
- Reset, then stream 0x11, 0x22, 0x33 with out_ready = 1 every cycle -> each appears 1 cycle after acceptance; occupancy stays at 1; in_ready is never low.
- Accept 0xA5 (reg 3, RegWrite = 1) and 0x5A (reg 4) with out_ready = 0:
  - occupancy = 2 and in_ready = 0.
  - A third in_valid is held off.
  - Raising out_ready drains 0xA5 then 0x5A in order.
- Assert flush while occupancy = 2 together with in_valid = 1 -> next cycle occupancy = 0, out_valid = 0, RegWrite_out = 0, in_ready = 1; the flushed input never appears.
- Head holds reg 5 with RegWrite = 1:
  - rs_a = 5, rs_b = 2 -> fwd_a_hit = 1, fwd_b_hit = 0.
  - Head is reg 0 with ZERO_REG_RO = 1 and rs_a = 0 -> fwd_a_hit = 0.
  - Same case with RegWrite = 0 -> no hits.
- Assert reset asynchronously mid-cycle while occupancy = 2 -> all outputs go to 0 immediately, before the next clk edge; after release the first accepted entry emerges correctly.
- Re-run with DATA_W = 32 and REG_ADDR_W = 5: 0xDEADBEEF to reg 31 passes through bit-exact; random valid/ready stress against a scoreboard shows no loss, duplication or reordering.

Source files
------------

// File: rtl/ex_wb_pipe_stage.sv
// EX->WB pipeline register with valid/ready handshake, a two-entry skid buffer,
// synchronous flush and forwarding-hit flags for the ID/EX hazard logic.
module ex_wb_pipe_stage #(
  parameter int DATA_W      = 8,
  parameter int REG_ADDR_W  = 3,
  parameter bit ZERO_REG_RO = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  RegWrite_in,
  input  logic [DATA_W-1:0]     ALU_result_in,
  input  logic [REG_ADDR_W-1:0] Write_reg_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  RegWrite_out,
  output logic [DATA_W-1:0]     ALU_result_out,
  output logic [REG_ADDR_W-1:0] Write_reg_out,
  input  logic [REG_ADDR_W-1:0] rs_a,
  input  logic [REG_ADDR_W-1:0] rs_b,
  output logic                  fwd_a_hit,
  output logic                  fwd_b_hit,
  output logic [1:0]            occupancy
);

  typedef struct packed {
    logic                  reg_write;
    logic [DATA_W-1:0]     result;
    logic [REG_ADDR_W-1:0] dest;
  } entry_t;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t head_q, skid_q, in_entry;
  logic   acc, pop;
  logic   load_head_in, load_head_skid, load_skid;

  assign in_entry  = '{reg_write: RegWrite_in, result: ALU_result_in, dest: Write_reg_in};
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign occupancy = state_q;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (acc) begin
          state_d      = ONE;
          load_head_in = 1'b1;
        end
        ONE: begin
          if (acc && pop) begin
            load_head_in = 1'b1;
          end else if (acc) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: if (pop) begin
          state_d        = ONE;
          load_head_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // NOTE: the data registers are reset too, because every output must read 0 in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      // Data is kept; only the write-enables are killed.
      head_q.reg_write <= 1'b0;
      skid_q.reg_write <= 1'b0;
    end else begin
      if (load_head_in)        head_q <= in_entry;
      else if (load_head_skid) head_q <= skid_q;
      if (load_skid)           skid_q <= in_entry;
    end
  end

  assign RegWrite_out   = out_valid & head_q.reg_write;
  assign ALU_result_out = head_q.result;
  assign Write_reg_out  = head_q.dest;

  assign fwd_a_hit = RegWrite_out & (head_q.dest == rs_a) & ~(ZERO_REG_RO && (rs_a == '0));
  assign fwd_b_hit = RegWrite_out & (head_q.dest == rs_b) & ~(ZERO_REG_RO && (rs_b == '0));

endmodule

// File: tb/tb_ex_wb_pipe_stage.sv
// Bench for ex_wb_pipe_stage: an 8/3 and a 32/5 instance share one stimulus
// and are checked against a queue model every cycle, plus literal expectations.
module tb_ex_wb_pipe_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready, rw_in;
  logic [31:0] data_in;
  logic [4:0]  wr_in, rs_a, rs_b;

  logic       in_ready8, out_valid8, rw_out8, fa8, fb8;
  logic [7:0] data_out8;
  logic [2:0] wr_out8;
  logic [1:0] occ8;

  logic        in_ready32, out_valid32, rw_out32, fa32, fb32;
  logic [31:0] data_out32;
  logic [4:0]  wr_out32;
  logic [1:0]  occ32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_wb_pipe_stage dut8 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready8),
    .RegWrite_in(rw_in), .ALU_result_in(data_in[7:0]), .Write_reg_in(wr_in[2:0]),
    .out_valid(out_valid8), .out_ready(out_ready),
    .RegWrite_out(rw_out8), .ALU_result_out(data_out8), .Write_reg_out(wr_out8),
    .rs_a(rs_a[2:0]), .rs_b(rs_b[2:0]),
    .fwd_a_hit(fa8), .fwd_b_hit(fb8), .occupancy(occ8)
  );

  ex_wb_pipe_stage #(.DATA_W(32), .REG_ADDR_W(5), .ZERO_REG_RO(1'b1)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .RegWrite_in(rw_in), .ALU_result_in(data_in), .Write_reg_in(wr_in),
    .out_valid(out_valid32), .out_ready(out_ready),
    .RegWrite_out(rw_out32), .ALU_result_out(data_out32), .Write_reg_out(wr_out32),
    .rs_a(rs_a), .rs_b(rs_b),
    .fwd_a_hit(fa32), .fwd_b_hit(fb32), .occupancy(occ32)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a FIFO of at most two entries plus the last head shown.
  typedef struct {
    logic        rw;
    logic [31:0] data;
    logic [4:0]  wr;
  } entry_t;

  entry_t q[$];
  entry_t last_head;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      last_head = '{1'b0, 32'h0, 5'h0};
    end else if (flush) begin
      q.delete();
      last_head.rw = 1'b0;
    end else begin
      automatic bit acc = in_valid && (q.size() < 2);
      automatic bit pop = (q.size() > 0) && out_ready;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{rw_in, data_in, wr_in});
      if (q.size() > 0) last_head = q[0];
    end
  end

  // Compare process: every falling edge, both instances against the model.
  always @(negedge clk) begin
    automatic int  n  = q.size();
    automatic bit  v  = (n > 0);
    automatic bit  rw = v && last_head.rw;
    check("in_ready8",  in_ready8,  32'(n < 2));
    check("in_ready32", in_ready32, 32'(n < 2));
    check("out_valid8",  out_valid8,  32'(v));
    check("out_valid32", out_valid32, 32'(v));
    check("occ8",  occ8,  32'(n));
    check("occ32", occ32, 32'(n));
    check("rw_out8",  rw_out8,  32'(rw));
    check("rw_out32", rw_out32, 32'(rw));
    check("data8",  data_out8,  32'(last_head.data[7:0]));
    check("data32", data_out32, last_head.data);
    check("wr8",  wr_out8,  32'(last_head.wr[2:0]));
    check("wr32", wr_out32, 32'(last_head.wr));
    check("fa8",  fa8,  32'(rw && last_head.wr[2:0] == rs_a[2:0] && rs_a[2:0] != 0));
    check("fb8",  fb8,  32'(rw && last_head.wr[2:0] == rs_b[2:0] && rs_b[2:0] != 0));
    check("fa32", fa32, 32'(rw && last_head.wr == rs_a && rs_a != 0));
    check("fb32", fb32, 32'(rw && last_head.wr == rs_b && rs_b != 0));
  end

  task automatic drive(input logic v, input logic rw, input logic [31:0] d,
                       input logic [4:0] w, input logic rdy, input logic fl);
    in_valid  = v;
    rw_in     = rw;
    data_in   = d;
    wr_in     = w;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ov"},  {out_valid8, out_valid32}, 32'h0);
    check({tag, "_rw"},  {rw_out8, rw_out32}, 32'h0);
    check({tag, "_d8"},  data_out8, 32'h0);
    check({tag, "_d32"}, data_out32, 32'h0);
    check({tag, "_wr"},  {wr_out8, wr_out32}, 32'h0);
    check({tag, "_occ"}, {occ8, occ32}, 32'h0);
    check({tag, "_fwd"}, {fa8, fb8, fa32, fb32}, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    rs_a  = '0;
    rs_b  = '0;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    check_all_zero("reset");
    step();
    reset = 1'b0;
    #1;
    check("ready_after_reset", {in_ready8, in_ready32}, 32'h3);

    // Streaming at full throughput.
    drive(1, 1, 32'h11, 5'd1, 1, 0); step();
    check("s11_d", data_out32, 32'h11); check("s11_occ", occ32, 32'd1);
    drive(1, 1, 32'h22, 5'd2, 1, 0); step();
    check("s22_d", data_out32, 32'h22); check("s22_rdy", in_ready32, 32'd1);
    drive(1, 1, 32'h33, 5'd3, 1, 0); step();
    check("s33_d", data_out8, 32'h33); check("s33_occ", occ8, 32'd1);
    drive(0, 0, 0, 0, 1, 0); step();
    check("s_empty", occ32, 32'd0);

    // Back-pressure fills the skid buffer, then drains in order.
    drive(1, 1, 32'hA5, 5'd3, 0, 0); step();
    drive(1, 1, 32'h5A, 5'd4, 0, 0); step();
    check("fill_occ", occ32, 32'd2); check("fill_rdy", in_ready32, 32'd0);
    check("fill_head", data_out32, 32'hA5);
    drive(1, 1, 32'h77, 5'd6, 0, 0); step();
    check("held_off_occ", occ8, 32'd2); check("held_off_head", data_out8, 32'hA5);
    drive(0, 0, 0, 0, 1, 0); step();
    check("drain1_d", data_out32, 32'h5A); check("drain1_wr", wr_out32, 32'd4);
    step();
    check("drain2_occ", occ32, 32'd0);

    // Flush while full with a simultaneous input.
    drive(1, 1, 32'h10, 5'd1, 0, 0); step();
    drive(1, 1, 32'h20, 5'd2, 0, 0); step();
    drive(1, 1, 32'h99, 5'd5, 1, 1); step();
    check("flush_occ", occ32, 32'd0); check("flush_ov", out_valid32, 32'd0);
    check("flush_rw", rw_out32, 32'd0); check("flush_rdy", in_ready32, 32'd1);
    drive(0, 0, 0, 0, 0, 0); step();
    check("flush_stays_empty", occ8, 32'd0);

    // Forwarding flags.
    drive(1, 1, 32'h55, 5'd5, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    rs_a = 5'd5; rs_b = 5'd2; #1;
    check("fwd_a_hit", {fa8, fa32}, 32'h3); check("fwd_b_miss", {fb8, fb32}, 32'h0);
    drive(1, 1, 32'h66, 5'd0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    rs_a = 5'd0; rs_b = 5'd0; #1;
    check("fwd_zero_reg", {fa8, fb8, fa32, fb32}, 32'h0);
    drive(1, 0, 32'h77, 5'd5, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    rs_a = 5'd5; rs_b = 5'd5; #1;
    check("fwd_no_rw", {fa8, fb8, fa32, fb32}, 32'h0);
    drive(0, 0, 0, 0, 1, 0); step();

    // Asynchronous reset mid-cycle while full.
    drive(1, 1, 32'hC1, 5'd1, 0, 0); step();
    drive(1, 1, 32'hC2, 5'd2, 0, 0); step();
    check("pre_reset_occ", occ32, 32'd2);
    drive(0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    step();
    reset = 1'b0;
    drive(1, 1, 32'hDEADBEEF, 5'd31, 1, 0); step();
    check("wide_d32", data_out32, 32'hDEADBEEF); check("wide_wr32", wr_out32, 32'd31);
    check("wide_d8", data_out8, 32'hEF);         check("wide_wr8", wr_out8, 32'd7);
    check("wide_rw", {rw_out8, rw_out32}, 32'h3);

    // Random stress against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom, 5'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
      rs_a = 5'($urandom);
      rs_b = ($urandom_range(0, 1) == 0) ? wr_in : 5'($urandom);
      step();
    end
    drive(0, 0, 0, 0, 1, 0);
    step(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
